// File: rtl/limber_gnrl_ramsp_rmw_pkg.sv
// Shared types for the single-port RAM read-modify-write front end.
package limber_gnrl_ramsp_rmw_pkg;

  localparam int STATE_W = 3;

  // Controller states. The encodings are fixed so that debug probes and
  // other blocks can decode the state register directly.
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    MRG_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/limber_gnrl_ramsp_rmw_if.sv
// Request/response handshake bundle between a requester and the RMW block.
interface limber_gnrl_ramsp_rmw_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/limber_gnrl_bytemerge.sv
// Byte-lane merge: each byte comes from new_word when its strobe is set,
// otherwise from old_word. Purely combinational.
module limber_gnrl_bytemerge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);

  // Select every byte lane independently from the strobe bit.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DW/8; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/limber_gnrl_ramsp_rmw.sv
// Single-outstanding request front end for a single-port, no-reset RAM.
// Partial writes are done as read, byte-merge, write-back.
module limber_gnrl_ramsp_rmw
  import limber_gnrl_ramsp_rmw_pkg::*;
#(
  parameter int DP = 64,
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  limber_gnrl_ramsp_rmw_if.slave   bus,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_din,
  input  logic [DW-1:0]            ram_dout
);

  localparam int SW = DW/8;

  state_e          state_r;
  state_e          state_nxt_s;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [SW-1:0]   wstrb_r;
  logic [DW-1:0]   rdata_r;
  logic            err_r;

  logic            req_ready_s;
  logic            hs_s;
  logic            oob_s;
  logic            strb_zero_s;
  logic            strb_full_s;
  logic [31:0]     addr_ext_s;
  logic [DW-1:0]   merged_s;

  // Handshake qualifiers; req_ready depends only on the state register.
  assign req_ready_s = (state_r == IDLE);
  assign hs_s        = bus.req_valid & req_ready_s;
  assign addr_ext_s  = 32'(bus.req_addr);
  assign oob_s       = (addr_ext_s >= 32'(DP));
  assign strb_zero_s = (bus.req_wstrb == {SW{1'b0}});
  assign strb_full_s = (bus.req_wstrb == {SW{1'b1}});

  limber_gnrl_bytemerge #(.DW(DW)) u_bytemerge (
    .old_word (ram_dout),
    .new_word (wdata_r),
    .strb     (wstrb_r),
    .merged   (merged_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision: the request type is resolved once at handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          if (oob_s) begin
            state_nxt_s = RESP;
          end else if (bus.req_we && strb_zero_s) begin
            state_nxt_s = RESP;
          end else if (!bus.req_we) begin
            state_nxt_s = READ;
          end else if (strb_full_s) begin
            state_nxt_s = WRITE;
          end else begin
            state_nxt_s = MRG_RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:   state_nxt_s = RESP;
      MRG_RD: state_nxt_s = WRITE;
      WRITE:  state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture, read-data capture and merged-word write-back staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      wstrb_r <= {SW{1'b0}};
      rdata_r <= {DW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            wstrb_r <= bus.req_wstrb;
            rdata_r <= {DW{1'b0}};
            err_r   <= oob_s;
          end
        end
        READ:    rdata_r <= ram_dout;
        MRG_RD:  wdata_r <= merged_s;
        default: ;
      endcase
    end
  end

  // RAM drive decoded from the state register; address/data always come
  // from reset registers so they are never X, even when ram_cs is low.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_r;
    ram_din  = wdata_r;
    case (state_r)
      READ:   ram_cs = 1'b1;
      MRG_RD: ram_cs = 1'b1;
      WRITE: begin
        ram_cs = 1'b1;
        ram_we = we_r;
      end
      default: begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
      end
    endcase
  end

  // Handshake outputs; the response fields are held in registers until taken.
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;

endmodule

// File: tb/tb_limber_gnrl_ramsp_rmw.sv
// Directed bench for limber_gnrl_ramsp_rmw with a behavioural RAM model.
module tb_limber_gnrl_ramsp_rmw;

  localparam int DP = 64;
  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:DP-1];
  int            wr_cnt;
  int            cs_cnt;
  int            n_assert;
  int            n_fail;

  limber_gnrl_ramsp_rmw_if #(.DW(DW), .AW(AW)) bus ();

  limber_gnrl_ramsp_rmw #(.DP(DP), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read RAM model with clocked write, plus activity counters.
  assign ram_dout = (ram_addr < 7'd64) ? mem[ram_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (ram_cs) cs_cnt <= cs_cnt + 1;
    if (ram_cs && ram_we) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr < 7'd64) mem[ram_addr[5:0]] <= ram_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one request starting just after a rising edge; returns in cycle N+1.
  task automatic issue(input logic we, input logic [6:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    chk("req_ready_idle", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid and check latency (in cycles after N) and fields.
  task automatic wait_rsp(input string tag, input int lat, input logic [31:0] rd,
                          input logic err);
    int cyc;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_rdata"}, bus.rsp_rdata, rd);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
  endtask

  task automatic release_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    int wr0;
    int cs0;
    n_assert = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    cs_cnt   = 0;
    for (int i = 0; i < DP; i++) mem[i] = 32'h0;
    mem[3]  = 32'hDEADBEEF;
    mem[63] = 32'hCAFEF00D;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 7'd0;
    bus.req_wdata = 32'h0;
    bus.req_wstrb = 4'h0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_ram_cs", 32'(ram_cs), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write addr 5: RAM write in N+1, response in N+2
    wr0 = wr_cnt;
    issue(1'b1, 7'd5, 32'h11223344, 4'hF);
    chk("fw_ram_cs", 32'(ram_cs), 32'h1);
    chk("fw_ram_we", 32'(ram_we), 32'h1);
    chk("fw_ram_addr", 32'(ram_addr), 32'd5);
    chk("fw_ram_din", ram_din, 32'h11223344);
    wait_rsp("fw", 2, 32'h0, 1'b0);
    release_rsp("fw");
    chk("fw_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    chk("fw_mem5", mem[5], 32'h11223344);

    // Partial write (bytes 0 and 2), then read back
    wr0 = wr_cnt;
    issue(1'b1, 7'd5, 32'hAABBCCDD, 4'h5);
    chk("pw_mrg_we", 32'(ram_we), 32'h0);
    wait_rsp("pw", 3, 32'h0, 1'b0);
    release_rsp("pw");
    chk("pw_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    chk("rd5_ram_we", 32'(ram_we), 32'h0);
    wait_rsp("rd5", 2, 32'h11BB33DD, 1'b0);
    release_rsp("rd5");

    // Out-of-range read: error after one cycle, RAM untouched
    cs0 = cs_cnt;
    issue(1'b0, 7'd70, 32'h0, 4'h0);
    wait_rsp("oob70", 1, 32'h0, 1'b1);
    release_rsp("oob70");
    chk("oob70_cs_cnt", 32'(cs_cnt - cs0), 32'd0);

    // Boundary: addr == DP write is an error, addr DP-1 is a normal read
    cs0 = cs_cnt;
    issue(1'b1, 7'd64, 32'h12345678, 4'hF);
    wait_rsp("oob64", 1, 32'h0, 1'b1);
    release_rsp("oob64");
    chk("oob64_cs_cnt", 32'(cs_cnt - cs0), 32'd0);
    issue(1'b0, 7'd63, 32'h0, 4'h0);
    wait_rsp("rd63", 2, 32'hCAFEF00D, 1'b0);
    release_rsp("rd63");

    // Back-pressure: hold rsp_ready low for 5 cycles in RESP
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    wait_rsp("bp", 2, 32'h11BB33DD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_rdata", bus.rsp_rdata, 32'h11BB33DD);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    // A request offered on the RESP->IDLE edge is not taken
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 7'd3;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("noacc_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("noacc_ram_cs", 32'(ram_cs), 32'h0);
    chk("noacc_req_ready", 32'(bus.req_ready), 32'h1);
    issue(1'b0, 7'd3, 32'h0, 4'h0);
    wait_rsp("rd3", 2, 32'hDEADBEEF, 1'b0);
    release_rsp("rd3");

    // Reset during MRG_RD abandons the partial write
    issue(1'b1, 7'd7, 32'h77777777, 4'hF);
    wait_rsp("w7", 2, 32'h0, 1'b0);
    release_rsp("w7");
    wr0 = wr_cnt;
    issue(1'b1, 7'd7, 32'h0000BEEF, 4'h3);
    chk("mrg_cs", 32'(ram_cs), 32'h1);
    chk("mrg_we", 32'(ram_we), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_ram_cs", 32'(ram_cs), 32'h0);
    chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_no_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("rstmid_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    issue(1'b0, 7'd7, 32'h0, 4'h0);
    wait_rsp("rd7", 2, 32'h77777777, 1'b0);
    release_rsp("rd7");

    // Zero-strobe write: response after one cycle, no RAM access
    cs0 = cs_cnt;
    issue(1'b1, 7'd9, 32'hFFFFFFFF, 4'h0);
    wait_rsp("zs9", 1, 32'h0, 1'b0);
    release_rsp("zs9");
    chk("zs9_cs_cnt", 32'(cs_cnt - cs0), 32'd0);
    chk("zs9_mem9", mem[9], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/limber_gnrl_ramsp_rmw.md
LIMBER_GNRL_RAMSP_RMW -- requirements
Module: limber_gnrl_ramsp_rmw

Interface
REQ-001 The block SHALL have parameter DP, default 64, meaning RAM depth in words.
REQ-002 The block SHALL have parameter DW, default 32, meaning word width; DW SHALL be a multiple of 8.
REQ-003 The block SHALL have parameter AW, default 6, meaning address width.
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  in  1  meaning reset; one clock, reset is synchronous and active-high.
REQ-006 The block SHALL have port req_valid  in  1  meaning a request is offered.
REQ-007 The block SHALL have port req_ready  out  1  meaning the block accepts the request this cycle.
REQ-008 The block SHALL have port req_we  in  1  meaning 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr  in  AW  meaning word address.
REQ-010 The block SHALL have port req_wdata  in  DW  meaning write data.
REQ-011 The block SHALL have port req_wstrb  in  DW/8  meaning byte write enables.
REQ-012 The block SHALL have port rsp_valid  out  1  meaning a response is held.
REQ-013 The block SHALL have port rsp_ready  in  1  meaning the consumer takes the response.
REQ-014 The block SHALL have port rsp_rdata  out  DW  meaning read data (0 for writes).
REQ-015 The block SHALL have port rsp_err  out  1  meaning req_addr >= DP.
REQ-016 The block SHALL have ports ram_cs, ram_we (out, 1), ram_addr (out, AW) and ram_din (out, DW), meaning drive to the single-port no-reset RAM.
REQ-017 The block SHALL have port ram_dout  in  DW  meaning combinational RAM read data, valid in the same cycle as ram_cs=1 and ram_we=0.

Function
REQ-018 The FSM SHALL have states IDLE, READ, MRG_RD, WRITE and RESP, with exactly one request outstanding at a time.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready, and it latches we, addr, wdata and wstrb into internal registers.
REQ-020 On handshake, the next state SHALL be: RESP with err=1 if addr>=DP; else RESP if write with wstrb==0; else READ if read; else WRITE if wstrb is all-ones; else MRG_RD.
REQ-021 In READ, ram_cs=1, ram_we=0 and ram_addr=addr_q; ram_dout SHALL be captured into rdata_q; next state RESP.
REQ-022 In MRG_RD, ram_cs=1 and ram_we=0; the merged word SHALL take byte i from wdata_q when wstrb_q[i]=1, else from ram_dout, and be stored into wdata_q; next state WRITE.
REQ-023 In WRITE, ram_cs=1, ram_we=1 and ram_din=wdata_q; next state RESP.
REQ-024 In IDLE and RESP, ram_cs SHALL be 0; ram_we, ram_addr and ram_din SHALL be don't-care but driven, never X.
REQ-025 In RESP, rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1, after which the next state is IDLE.
REQ-026 Latency from handshake cycle N to first rsp_valid SHALL be: read N+2, full write N+2, partial write N+3, err/zero-strobe N+1.
REQ-027 There SHALL be no combinational path from req_valid or rsp_ready to req_ready; rsp_valid and req_ready SHALL be registered-state decodes.
REQ-028 A request in the same cycle as a RESP→IDLE transition SHALL NOT be accepted, because req_ready=0 in RESP.
REQ-029 Exactly one RAM write SHALL occur per accepted non-error write with nonzero strobe; reads SHALL never assert ram_we.

Reset
REQ-030 On rst=1 at a clock edge, the state SHALL become IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0, and the internal addr/wdata/wstrb/rdata registers cleared.
REQ-031 Reset mid-operation (READ, MRG_RD, WRITE or RESP) SHALL abandon the request with no response; ram_cs SHALL be 0 from the cycle after the reset edge.
REQ-032 RAM contents SHALL NOT be affected by reset.

Structure
REQ-033 State encodings (IDLE=0, READ=1, MRG_RD=2, WRITE=3, RESP=4; 3 bits) SHALL live in the shared include limber_gnrl_defines.vh.
REQ-034 The byte-merge logic SHALL be one combinational sub-module, limber_gnrl_bytemerge (params DW; ports old, new, strb, merged); the RAM itself SHALL be instantiated by the parent.

Verification
REQ-035 Reset, then write addr 5, data 0x11223344, wstrb 0xF → RAM write at N+1, rsp_valid at N+2, rsp_err=0.
REQ-036 Partial write addr 5, data 0xAABBCCDD, wstrb 0x5, then read addr 5 → rsp_rdata=0x11BB33DD.
REQ-037 Read addr 70 (DP=64) → rsp_err=1 at N+1, ram_cs never asserted.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-039 Assert rst during MRG_RD of a partial write to addr 7 → no RAM write, no response, then read addr 7 returns its prior value.
REQ-040 Write addr 9 with wstrb 0x0 → rsp at N+1 and no ram_cs activity.
